mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Memory-access stage and MEM/WB pipeline register of the RV32I core.
- Takes one instruction at a time from EX. Performs loads and stores over a ready/ack data-memory port, with byte/halfword alignment and sign/zero extension.
- Drives the register file's write port as `wb_we`/`wb_waddr`/`wb_wdata`, i.e. the writer side of the register file.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- ADDR_W, 32, width of the byte address and of `ex_alu`.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  EX presents an instruction this cycle
- ex_we  in  1  instruction writes rd
- ex_waddr  in  5  rd index
- ex_alu  in  ADDR_W  ALU result: rd value, or effective address for load/store
- ex_ld  in  1  instruction is a load
- ex_st  in  1  instruction is a store; ex_ld and ex_st never both 1
- ex_funct3  in  3  RV32I load/store funct3
- ex_sdata  in  32  store data (rs2)
- stall_req  out  1  combinational; upstream holds all ex_* stable while 1
- mem_req  out  1  memory request, registered
- mem_wr  out  1  1 = store, 0 = load
- mem_addr  out  ADDR_W  word-aligned address {ex_alu[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wmask  out  4  byte-lane enables, 0 for loads
- mem_rdata  in  32  load word, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion pulse
- wb_we  out  1  register-file write enable (1-cycle pulse per instruction)
- wb_waddr  out  5  register-file write address
- wb_wdata  out  32  register-file write data
- fault  out  1  1-cycle pulse: misaligned access or illegal funct3

Behaviour:
- Reset: on a clk edge with rst=1, state=IDLE and every registered output = 0 (mem_req, mem_wr, mem_addr, mem_wdata, mem_wmask, wb_we, wb_waddr, wb_wdata, fault). rst has priority over all other inputs.
- Reset mid-BUSY aborts the access. mem_ack arriving in IDLE is ignored.
- FSM states: IDLE, BUSY.
- Default every cycle: wb_we=0, fault=0. wb_waddr and wb_wdata hold their last value.
- IDLE, ex_valid=1, non-memory op:
  - next edge: wb_we=ex_we, wb_waddr=ex_waddr, wb_wdata=ex_alu.
  - Latency 1 cycle; no stall.
- IDLE, ex_valid=1, memory op with a fault condition:
  - Fault conditions: halfword op with ex_alu[0]=1; word op with ex_alu[1:0]≠0; load funct3 ∈ {011,110,111}; store funct3 ∉ {000,001,010}.
  - Response: no memory request, fault=1 next edge, wb_we=0, no stall.
- IDLE, ex_valid=1, legal memory op:
  - stall_req=1 combinationally.
  - Next edge: state=BUSY, mem_req=1, mem_wr=ex_st, mem_addr word-aligned.
  - Lane k = ex_alu[1:0].
  - SB: wdata={4{sdata[7:0]}}, mask=1<<k.
  - SH: wdata={2{sdata[15:0]}}, mask=4'b0011<<k.
  - SW: wdata=sdata, mask=4'b1111.
  - Loads: mask=0.
- BUSY:
  - mem_req and all mem_* outputs held stable until mem_ack.
  - stall_req = !mem_ack.
  - On the mem_ack edge: state=IDLE, mem_req=0.
  - Load on ack: wb_we=ex_we, wb_waddr=ex_waddr, wb_wdata = the selected lane of mem_rdata, extended:
    - LB: sign-extend byte k.
    - LBU: zero-extend byte k.
    - LH: sign-extend halfword k[1].
    - LHU: zero-extend halfword k[1].
    - LW: full word.
  - Store on ack: wb_we=0.
- mem_ack may arrive as early as the first BUSY cycle.
  - Minimum load-to-writeback latency: 2 edges after the instruction is presented.
  - Upstream advances on the ack cycle, since stall_req falls in that cycle.
- Back-to-back instructions:
  - Next instruction is sampled in IDLE on the edge after the ack.
  - No bubble for non-memory ops following non-memory ops.
- ex_valid=0 in IDLE: no action, stall_req=0.
- x0 writes are passed through unchanged.

Test Plan:
- Reset: hold rst=1 while mem_ack toggles → all outputs 0, stall_req=0, state stays IDLE.
- ALU op: ex_we=1, waddr=5, alu=0x1234 → next cycle wb_we=1, wb_waddr=5, wb_wdata=0x1234; following cycle wb_we=0.
- LB: alu=0x103, mem_rdata=0x80FF_0000, ack after 3 BUSY cycles → mem_addr=0x100, stall_req=1 until the ack cycle, wb_wdata=0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH: alu=0x202, sdata=0xABCD → mem_addr=0x200, mem_wdata=0xABCDABCD, mem_wmask=4'b1100, mem_wr=1, no wb_we.
- LW at alu=0x101 → fault pulse, mem_req never asserted, no stall. Load funct3=011 → fault.
- Reset mid-BUSY: rst asserted one cycle into an LW → next edge mem_req=0, IDLE; a subsequent mem_ack produces no wb_we.

Source files
------------

// File: rtl/mem_wb_stage.sv
// RV32I memory-access stage and MEM/WB register: issues aligned loads/stores
// over a ready/ack port, extends load data and drives the register-file write port.
module mem_wb_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic [4:0]        ex_waddr,
  input  logic [ADDR_W-1:0] ex_alu,
  input  logic              ex_ld,
  input  logic              ex_st,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_sdata,
  output logic              stall_req,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_we,
  output logic [4:0]        wb_waddr,
  output logic [31:0]       wb_wdata,
  output logic              fault
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;

  logic       is_mem, mis, illegal, bad, go;
  logic [1:0] lane;
  logic [31:0] st_data;
  logic [3:0]  st_mask;

  // Load context captured at issue so the ack cycle does not depend on ex_*.
  logic       pend_ld, pend_we;
  logic [2:0] pend_f3;
  logic [1:0] pend_lane;
  logic [4:0] pend_waddr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign lane   = ex_alu[1:0];
  assign is_mem = ex_ld | ex_st;

  always_comb begin
    mis = 1'b0;
    case (ex_funct3[1:0])
      2'b01:   mis = ex_alu[0];
      2'b10:   mis = |ex_alu[1:0];
      default: mis = 1'b0;
    endcase
    illegal = ex_ld ? (ex_funct3 == 3'b011 || ex_funct3[2:1] == 2'b11)
                    : (ex_funct3 > 3'b010);
    bad = mis | illegal;
  end

  assign go = (state == IDLE) && ex_valid && is_mem && !bad;

  always_comb begin
    st_data = ex_sdata;
    st_mask = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        st_data = {4{ex_sdata[7:0]}};
        st_mask = 4'b0001 << lane;
      end
      2'b01: begin
        st_data = {2{ex_sdata[15:0]}};
        st_mask = 4'b0011 << lane;
      end
      default: begin
        st_data = ex_sdata;
        st_mask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[{pend_lane, 3'b000} +: 8];
    ld_half = mem_rdata[{pend_lane[1], 4'b0000} +: 16];
    case (pend_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = BUSY;
      BUSY:    if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Upstream may advance in the ack cycle itself.
  always_comb begin
    stall_req = go || (state == BUSY && !mem_ack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      wb_we      <= 1'b0;
      wb_waddr   <= '0;
      wb_wdata   <= '0;
      fault      <= 1'b0;
      pend_ld    <= 1'b0;
      pend_we    <= 1'b0;
      pend_f3    <= '0;
      pend_lane  <= '0;
      pend_waddr <= '0;
    end else begin
      wb_we <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: if (ex_valid) begin
          if (!is_mem) begin
            wb_we    <= ex_we;
            wb_waddr <= ex_waddr;
            wb_wdata <= 32'(ex_alu);
          end else if (bad) begin
            fault <= 1'b1;
          end else begin
            mem_req    <= 1'b1;
            mem_wr     <= ex_st;
            mem_addr   <= {ex_alu[ADDR_W-1:2], 2'b00};
            mem_wdata  <= st_data;
            mem_wmask  <= ex_st ? st_mask : 4'b0000;
            pend_ld    <= ex_ld;
            pend_we    <= ex_we;
            pend_f3    <= ex_funct3;
            pend_lane  <= lane;
            pend_waddr <= ex_waddr;
          end
        end
        BUSY: if (mem_ack) begin
          mem_req <= 1'b0;
          if (pend_ld) begin
            wb_we    <= pend_we;
            wb_waddr <= pend_waddr;
            wb_wdata <= ld_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
